// File: rtl/dma_copy_master.sv
// dma_copy_master
//   Word-granular DMA initiator. It copies cfg_len 16-bit words from cfg_src
//   to cfg_dst over the shared DMA port. Each word is one read followed by one
//   write. The monitor's reset (kill) aborts the transfer immediately.
//
// Ports
//   clk, reset_n          clock, synchronous active-low reset
//   cfg_src/dst/len       transfer programming, sampled when start is accepted
//   start                 one-cycle request, honoured only in IDLE
//   kill                  abort; also gates dma_en combinationally
//   dma_ready/dout/resp   memory handshake, read data, error response
//   dma_addr/din/en/we    memory request
//   busy, done, err       status towards the register file
module dma_copy_master #(
  parameter logic [15:0] MAX_LEN = 16'h0800
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] cfg_src,
  input  logic [15:0] cfg_dst,
  input  logic [15:0] cfg_len,
  input  logic        start,
  input  logic        kill,
  input  logic        dma_ready,
  input  logic [15:0] dma_dout,
  input  logic        dma_resp,
  output logic [15:0] dma_addr,
  output logic [15:0] dma_din,
  output logic        dma_en,
  output logic [1:0]  dma_we,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT} state_t;

  state_t      state;
  logic [15:0] src_q;
  logic [15:0] dst_q;
  logic [15:0] len_q;
  logic        en_q;

  logic [15:0] src_al;
  logic [15:0] dst_al;
  logic [15:0] len_dec;
  logic        start_bad;

  // True when a block of len words starting at base runs past the top of the
  // 64 KiB space. The widened sum keeps the carry out of the 16-bit address.
  function automatic logic range_bad(input logic [15:0] base, input logic [15:0] len);
    logic [17:0] end_addr;
    end_addr = {2'b00, base} + {1'b0, len, 1'b0};
    return end_addr > 18'h10000;
  endfunction

  assign src_al    = {cfg_src[15:1], 1'b0};
  assign dst_al    = {cfg_dst[15:1], 1'b0};
  assign len_dec   = len_q - 16'd1;
  assign start_bad = (cfg_len > MAX_LEN) || range_bad(src_al, cfg_len) ||
                     range_bad(dst_al, cfg_len);

  // The request is registered, but a kill cycle must never present an access.
  assign dma_en = en_q & ~kill;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      en_q     <= 1'b0;
      dma_addr <= '0;
      dma_din  <= '0;
      dma_we   <= 2'b00;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (state != IDLE && kill) begin
        // Abort without touching the counters.
        state  <= IDLE;
        en_q   <= 1'b0;
        dma_we <= 2'b00;
        busy   <= 1'b0;
        err    <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (start && !kill) begin
              if (start_bad) begin
                err <= 1'b1;
              end else if (cfg_len == 16'd0) begin
                done <= 1'b1;
              end else begin
                src_q    <= src_al;
                dst_q    <= dst_al;
                len_q    <= cfg_len;
                state    <= RD_REQ;
                en_q     <= 1'b1;
                dma_addr <= src_al;
                dma_we   <= 2'b00;
                busy     <= 1'b1;
              end
            end
          end
          RD_REQ: begin
            if (dma_ready) begin
              state <= RD_WAIT;
              en_q  <= 1'b0;
            end
          end
          RD_WAIT: begin
            if (dma_resp) begin
              state <= IDLE;
              busy  <= 1'b0;
              err   <= 1'b1;
            end else begin
              // dma_din doubles as the word buffer between read and write.
              state    <= WR_REQ;
              en_q     <= 1'b1;
              dma_addr <= dst_q;
              dma_din  <= dma_dout;
              dma_we   <= 2'b11;
            end
          end
          WR_REQ: begin
            if (dma_ready) begin
              state  <= WR_WAIT;
              en_q   <= 1'b0;
              dma_we <= 2'b00;
            end
          end
          WR_WAIT: begin
            if (dma_resp) begin
              state <= IDLE;
              busy  <= 1'b0;
              err   <= 1'b1;
            end else begin
              src_q <= src_q + 16'd2;
              dst_q <= dst_q + 16'd2;
              len_q <= len_dec;
              if (len_dec == 16'd0) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state    <= RD_REQ;
                en_q     <= 1'b1;
                dma_addr <= src_q + 16'd2;
              end
            end
          end
          default: begin
            state <= IDLE;
            en_q  <= 1'b0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/dma_copy_master.md
# dma_copy_master

Word-granular DMA initiator that copies a block of memory from a source address to a destination address over the shared DMA port. It is the master end of the DMA address/enable interface that the VRASED DMA monitor snoops. It stops the moment that monitor's reset is asserted, so a killed access never completes. It is programmed by a single-cycle start pulse from the peripheral register file and reports busy, done and error status back to it.

## Interface

Parameters:
- MAX_LEN, 16'h0800: largest accepted transfer length, in words.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- cfg_src  input  16  source byte address; bit 0 is ignored and treated as 0.
- cfg_dst  input  16  destination byte address; bit 0 is ignored and treated as 0.
- cfg_len  input  16  transfer length in 16-bit words.
- start  input  1  one-cycle request; sampled only in IDLE.
- kill  input  1  abort request, driven by the DMA monitor's reset output.
- dma_ready  input  1  memory accepts the current request this cycle.
- dma_dout  input  16  read data, valid the cycle after a read is accepted.
- dma_resp  input  1  error response, valid with dma_dout; also checked the cycle after a write is accepted.
- dma_addr  output  16  request address, always word-aligned.
- dma_din  output  16  write data.
- dma_en  output  1  request valid.
- dma_we  output  2  byte write enables; 2'b11 for writes, 2'b00 for reads.
- busy  output  1  high from the cycle after start is accepted until the terminal state.
- done  output  1  one-cycle pulse on successful completion.
- err  output  1  one-cycle pulse on rejection, abort or bus error.

## Operation

States:
- IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT.

Start checks in IDLE (start=1, kill=0):
- Error start: `cfg_len > MAX_LEN`, or src/dst address overflow. Overflow means src + 2*len > 17'h10000 or dst + 2*len > 17'h10000, computed at 17-bit width. Required response: err pulse, stay in IDLE, no bus activity.
- Zero-length start (cfg_len == 0): done pulse next cycle, stay in IDLE, no bus activity.
- Otherwise: latch src, dst and len into internal counters and go to RD_REQ.

Transfer sequence:
- RD_REQ: dma_en=1, dma_addr=src, dma_we=0. Hold until dma_ready=1, then go to RD_WAIT.
- RD_WAIT: capture dma_dout into the data buffer.
  - dma_resp=1: err pulse, go to IDLE.
  - Otherwise: go to WR_REQ.
- WR_REQ: dma_en=1, dma_addr=dst, dma_din=buffer, dma_we=2'b11. Hold until dma_ready=1, then go to WR_WAIT.
- WR_WAIT:
  - dma_resp=1: err pulse, go to IDLE.
  - Otherwise: src+=2, dst+=2, len-=1. If the new len is 0, done pulse and go to IDLE; else go to RD_REQ.

Request rules:
- dma_addr, dma_din and dma_we stay stable while dma_en=1 and dma_ready=0.
- dma_en=0 in IDLE, RD_WAIT and WR_WAIT.

Kill:
- In any non-IDLE state, kill=1 forces IDLE on the next edge with an err pulse. No counter update occurs.
- dma_en is combinationally gated by !kill, so an access is never presented during a kill cycle.
- In IDLE, kill=1 blocks start: start with kill=1 is ignored, with no err pulse.

Other rules:
- start while busy is ignored.
- done and err are never high together.

## Timing

- Reset (reset_n=0 at a clock edge), on the next edge:
  - State IDLE; all counters and the buffer cleared.
  - dma_en=0, dma_we=0, dma_addr=0, dma_din=0, busy=0, done=0, err=0.
  - Reset mid-transfer discards the transfer silently, with no err pulse.
- Best case with dma_ready tied high: 4 cycles per word. A transfer of N words takes 4N cycles from the start-accept edge to the done pulse.
- busy rises on the edge that accepts start and falls on the edge that raises done or err.
- dma_en rises on the edge after start is accepted.
- Reset-held outputs: all outputs are registered except dma_en, which is a registered request ANDed with !kill.

## Test plan

- **Basic copy:** src=16'h1000, dst=16'h2000, len=3, dma_ready=1 -> reads 1000/1002/1004 and writes 2000/2002/2004 carry matching data; done pulses 12 cycles after start; busy is high for exactly those 12 cycles.
- **Backpressure:** dma_ready=0 for 5 cycles during the first RD_REQ -> dma_addr holds 16'h1000 with dma_en=1 throughout; done arrives 5 cycles later than in the basic copy.
- **Kill mid-transfer:** kill pulsed during WR_REQ of word 2 of len=4 -> dma_en=0 in the same cycle; err pulses one cycle later; no write to dst+2 occurs; busy=0.
- **Start rejection:** src=16'hFFFC with len=3 -> err pulse, zero bus requests. len=0 -> done pulse, zero bus requests. len=MAX_LEN+1 -> err pulse.
- **Bus error:** dma_resp=1 on the read of word 1 -> err pulse; no write issued; return to IDLE.
- **Reset and stray start:** reset_n=0 in RD_WAIT -> all outputs 0 on the next edge, no err. A start asserted while busy is ignored and the transfer length is unchanged.
